// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking, PWM dimming
// and frame-aligned double-buffered updates over a valid/ready handshake.
module seven_seg_scan_ctrl #(
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [15:0] upd_digits,
   input  logic [3:0]  upd_dp,
   input  logic [3:0]  upd_en,
   input  logic [3:0]  upd_bright,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int TW = $clog2(CLK_DIV);
   localparam logic [TW-1:0] LAST = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] BLK  = TW'(BLANK_CYCLES);

   logic [TW-1:0] tick_cnt;
   logic [1:0]    digit_idx;
   logic [3:0]    pwm_cnt;

   logic          stg_full;
   logic [15:0]   stg_digits;
   logic [3:0]    stg_dp;
   logic [3:0]    stg_en;
   logic [3:0]    stg_bright;

   logic [15:0]   act_digits;
   logic [3:0]    act_dp;
   logic [3:0]    act_en;
   logic [3:0]    act_bright;

   logic          tick_last;
   logic          boundary;
   logic          on_phase;
   logic          lit;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;

   assign tick_last = (tick_cnt == LAST);
   assign boundary  = tick_last && (digit_idx == 2'd3);
   assign on_phase  = (tick_cnt >= BLK);
   assign upd_ready = ~stg_full;
   assign nib       = act_digits[{digit_idx, 2'b00} +: 4];

   assign lit = on_phase && act_en[digit_idx] &&
                ((act_bright == 4'hF) || (pwm_cnt < act_bright));

   always_comb begin
      seg_dec = 7'h7F;
      unique case (nib)
         4'h0: seg_dec = 7'b1000000;
         4'h1: seg_dec = 7'b1111001;
         4'h2: seg_dec = 7'b0100100;
         4'h3: seg_dec = 7'b0110000;
         4'h4: seg_dec = 7'b0011001;
         4'h5: seg_dec = 7'b0010010;
         4'h6: seg_dec = 7'b0000010;
         4'h7: seg_dec = 7'b1111000;
         4'h8: seg_dec = 7'b0000000;
         4'h9: seg_dec = 7'b0010000;
         4'hA: seg_dec = 7'b0001000;
         4'hB: seg_dec = 7'b0000011;
         4'hC: seg_dec = 7'b1000110;
         4'hD: seg_dec = 7'b0100001;
         4'hE: seg_dec = 7'b0000110;
         4'hF: seg_dec = 7'b0001110;
      endcase
   end

   // pwm_cnt reads 0 on the first ON cycle and stays 0 through blanking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt  <= '0;
         digit_idx <= 2'd0;
         pwm_cnt   <= 4'd0;
      end else begin
         tick_cnt <= tick_last ? '0 : tick_cnt + TW'(1);
         if (tick_last)
            digit_idx <= digit_idx + 2'd1;
         if (tick_last || (tick_cnt < BLK))
            pwm_cnt <= 4'd0;
         else
            pwm_cnt <= pwm_cnt + 4'd1;
      end
   end

   // staging can never fill and drain in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_full   <= 1'b0;
         stg_digits <= 16'h0;
         stg_dp     <= 4'h0;
         stg_en     <= 4'h0;
         stg_bright <= 4'h0;
         act_digits <= 16'h0;
         act_dp     <= 4'h0;
         act_en     <= 4'h0;
         act_bright <= 4'hF;
      end else if (boundary && stg_full) begin
         stg_full   <= 1'b0;
         act_digits <= stg_digits;
         act_dp     <= stg_dp;
         act_en     <= stg_en;
         act_bright <= stg_bright;
      end else if (upd_valid && !stg_full) begin
         stg_full   <= 1'b1;
         stg_digits <= upd_digits;
         stg_dp     <= upd_dp;
         stg_en     <= upd_en;
         stg_bright <= upd_bright;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an         <= 4'hF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (lit) begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_dec;
            dp  <= ~act_dp[digit_idx];
         end else begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
         end
      end
   end

endmodule
